// File: rtl/spi_master_xfer_if.sv
// Command/response bus between the CPU-side bridge and spi_master_xfer.
// master: requester side; slave: the SPI master block that serves commands.
interface spi_master_xfer_if #(
  parameter int unsigned SS_W = 8
);
  logic            req_valid;
  logic            req_ready;
  logic [63:0]     req_data;
  logic [5:0]      req_len;
  logic [SS_W-1:0] req_ss;
  logic            resp_valid;
  logic [63:0]     resp_data;

  modport master (
    output req_valid, req_data, req_len, req_ss,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_data, req_len, req_ss,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/spi_master_xfer.sv
// SPI mode-0 master, MSB first: one command -> one full-duplex transfer of 1..64 bits.
// Optional macro SPI_SAMPLE_FALL_EN moves miso sampling to the sck falling edge.
module spi_master_xfer #(
  parameter int unsigned DIV  = 1,
  parameter int unsigned SS_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  spi_master_xfer_if.slave bus,
  output logic            sck,
  output logic [SS_W-1:0] ss,
  output logic            mosi,
  input  logic            miso
);
  localparam int unsigned PW = $clog2(DIV) + 1;

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, DONE} state_t;

  state_t          r_state, w_state_next;
  logic [PW-1:0]   r_phase;
  logic [6:0]      r_cnt;
  logic [63:0]     r_tx;
  logic [63:0]     r_rx;
  logic [63:0]     r_resp_data;
  logic            r_resp_valid;
  logic            r_sck;
  logic            r_mosi;
  logic [SS_W-1:0] r_ss;

  logic [6:0]      w_len;
  logic [63:0]     w_tx_aligned;
  logic            w_half_end;
  logic            w_trail_end;
  logic            w_sample;

  assign w_len        = (bus.req_len == 6'd0) ? 7'd64 : {1'b0, bus.req_len};
  // Left-justify so the first bit to send always sits in bit 63.
  assign w_tx_aligned = bus.req_data << (7'd64 - w_len);
  assign w_half_end   = (r_phase == PW'(DIV - 1));
  assign w_trail_end  = (r_phase == PW'(2 * DIV - 1));

`ifdef SPI_SAMPLE_FALL_EN
  assign w_sample = (r_state == HIGH) && w_half_end;
`else
  assign w_sample = ((r_state == LEAD) || (r_state == LOW)) && w_half_end;
`endif

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign sck            = r_sck;
  assign ss             = r_ss;
  assign mosi           = r_mosi;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // TRAIL spans the last bit's low half-period plus the select hold time,
  // so it lasts two half-periods and the transfer is whole sck periods long.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (bus.req_valid) w_state_next = LEAD;
      LEAD:  if (w_half_end)    w_state_next = HIGH;
      HIGH:  if (w_half_end)    w_state_next = (r_cnt == 7'd1) ? TRAIL : LOW;
      LOW:   if (w_half_end)    w_state_next = HIGH;
      TRAIL: if (w_trail_end)   w_state_next = DONE;
      DONE:                     w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase      <= '0;
      r_cnt        <= '0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_resp_data  <= '0;
      r_resp_valid <= 1'b0;
      r_sck        <= 1'b0;
      r_mosi       <= 1'b1;
      r_ss         <= '1;
    end else begin
      if ((w_state_next != r_state) || (r_state == IDLE)) r_phase <= '0;
      else                                                r_phase <= r_phase + 1'b1;
      r_resp_valid <= 1'b0;
      if (w_sample) r_rx <= {r_rx[62:0], miso};
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_tx   <= w_tx_aligned;
          r_cnt  <= w_len;
          r_rx   <= '0;
          r_ss   <= ~bus.req_ss;
          r_sck  <= 1'b0;
          r_mosi <= w_tx_aligned[63];
        end
        LEAD: if (w_half_end) r_sck <= 1'b1;
        HIGH: if (w_half_end) begin
          r_sck <= 1'b0;
          if (r_cnt != 7'd1) begin
            r_tx   <= {r_tx[62:0], 1'b0};
            r_mosi <= r_tx[62];
            r_cnt  <= r_cnt - 7'd1;
          end
        end
        LOW: if (w_half_end) r_sck <= 1'b1;
        TRAIL: if (w_trail_end) begin
          r_ss         <= '1;
          r_mosi       <= 1'b1;
          r_resp_valid <= 1'b1;
          r_resp_data  <= r_rx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_xfer.sv
// Directed bench for spi_master_xfer: DIV=1 and DIV=2 instances, loopback vectors
// plus hand sequences for held req_valid, mid-transfer reset and a posedge-driven slave.
module tb_spi_master_xfer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        tb_sel   = 1'b0;
  logic        tb_valid = 1'b0;
  logic        tb_loop  = 1'b1;
  logic [63:0] tb_data  = '0;
  logic [5:0]  tb_len   = '0;
  logic [7:0]  tb_ss    = '0;

  spi_master_xfer_if #(.SS_W(8)) if1 ();
  spi_master_xfer_if #(.SS_W(8)) if2 ();

  logic       sck1, sck2, mosi1, mosi2, miso1, miso2;
  logic [7:0] ss1, ss2;

  assign if1.req_valid = tb_valid && !tb_sel;
  assign if1.req_data  = tb_data;
  assign if1.req_len   = tb_len;
  assign if1.req_ss    = tb_ss;
  assign if2.req_valid = tb_valid && tb_sel;
  assign if2.req_data  = tb_data;
  assign if2.req_len   = tb_len;
  assign if2.req_ss    = tb_ss;

  spi_master_xfer #(.DIV(1), .SS_W(8)) u_div1 (
    .clock(clock), .reset(reset), .bus(if1),
    .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(miso1)
  );
  spi_master_xfer #(.DIV(2), .SS_W(8)) u_div2 (
    .clock(clock), .reset(reset), .bus(if2),
    .sck(sck2), .ss(ss2), .mosi(mosi2), .miso(miso2)
  );

  // Slave that launches its next bit on every sck rise, starting from 0.
  logic       sl_load = 1'b0;
  logic [7:0] sl_sh;
  logic       sl_miso;
  always @(posedge sck1 or posedge sl_load) begin
    if (sl_load) begin
      sl_sh   <= 8'h3C;
      sl_miso <= 1'b0;
    end else begin
      sl_miso <= sl_sh[7];
      sl_sh   <= {sl_sh[6:0], 1'b0};
    end
  end

  assign miso1 = tb_loop ? mosi1 : sl_miso;
  assign miso2 = mosi2;

  logic        w_ready, w_rv, w_sck, w_mosi;
  logic [63:0] w_rd;
  logic [7:0]  w_ss;
  assign w_ready = tb_sel ? if2.req_ready  : if1.req_ready;
  assign w_rv    = tb_sel ? if2.resp_valid : if1.resp_valid;
  assign w_rd    = tb_sel ? if2.resp_data  : if1.resp_data;
  assign w_sck   = tb_sel ? sck2  : sck1;
  assign w_mosi  = tb_sel ? mosi2 : mosi1;
  assign w_ss    = tb_sel ? ss2   : ss1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Called at #1 after the accept edge; returns at #1 after the edge that raised resp_valid.
  task automatic wait_resp(output logic [63:0] got, output int lat, output int rises,
                           output int highcyc, output int sscyc, output int readyhi,
                           output logic [8:0] done_ssmosi, output bit found);
    logic prev = 1'b0;
    got = '0; lat = 0; rises = 0; highcyc = 0; sscyc = 0; readyhi = 0;
    done_ssmosi = '0; found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (w_rv) begin
        lat = k + 1;
        got = w_rd;
        done_ssmosi = {w_ss, w_mosi};
        found = 1'b1;
        break;
      end
      if (w_sck && !prev) rises++;
      if (w_sck) highcyc++;
      if (w_ss != 8'hFF) sscyc++;
      if (w_ready) readyhi++;
      prev = w_sck;
      @(posedge clock); #1;
    end
  endtask

  typedef struct {
    logic        sel;
    logic [5:0]  len;
    logic [63:0] data;
    logic [7:0]  mask;
    logic [63:0] exp_data;
    int          exp_lat;
    int          exp_rises;
    int          exp_high;
    int          exp_ss;
  } vec_t;

  vec_t vecs[7];

  logic [63:0] got;
  int          lat, rises, highcyc, sscyc, readyhi, cnt;
  logic [8:0]  dsm;
  bit          found;
  logic [63:0] exp6;

  initial begin
    vecs[0] = '{1'b0, 6'd8,  64'hA5,               8'h01, 64'hA5,               19,  8,  8,  18};
    vecs[1] = '{1'b1, 6'd16, 64'h1234,             8'h02, 64'h1234,             69,  16, 32, 68};
    vecs[2] = '{1'b0, 6'd0,  64'hDEADBEEF01234567, 8'h80, 64'hDEADBEEF01234567, 131, 64, 64, 130};
    vecs[3] = '{1'b0, 6'd1,  64'h1,                8'h01, 64'h1,                5,   1,  1,  4};
    vecs[4] = '{1'b0, 6'd5,  64'hFF,               8'h0F, 64'h1F,               13,  5,  5,  12};
    vecs[5] = '{1'b1, 6'd3,  64'h5,                8'h00, 64'h5,                17,  3,  6,  0};
    vecs[6] = '{1'b0, 6'd63, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h7FFFFFFFFFFFFFFF, 129, 63, 63, 128};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready",      {63'd0, if1.req_ready},  64'd1);
    chk("rst_resp_valid", {63'd0, if1.resp_valid}, 64'd0);
    chk("rst_resp_data",  if1.resp_data,           64'd0);
    chk("rst_sck_mosi",   {62'd0, sck1, mosi1},    64'd1);
    chk("rst_ss",         {56'd0, ss1},            64'hFF);
    chk("rst_div2",       {53'd0, if2.req_ready, if2.resp_valid, sck2, ss2}, {53'd0, 3'b100, 8'hFF});
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 7; i++) begin
      tb_sel = vecs[i].sel; tb_len = vecs[i].len; tb_data = vecs[i].data; tb_ss = vecs[i].mask;
      tb_valid = 1'b1;
      @(posedge clock); #1;
      tb_valid = 1'b0;
      wait_resp(got, lat, rises, highcyc, sscyc, readyhi, dsm, found);
      chk($sformatf("v%0d_found", i),   {63'd0, found}, 64'd1);
      chk($sformatf("v%0d_data", i),    got, vecs[i].exp_data);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_sck_rises", i), 64'(rises), 64'(vecs[i].exp_rises));
      chk($sformatf("v%0d_sck_high", i),  64'(highcyc), 64'(vecs[i].exp_high));
      chk($sformatf("v%0d_ss_cycles", i), 64'(sscyc), 64'(vecs[i].exp_ss));
      chk($sformatf("v%0d_ready_busy", i), 64'(readyhi), 64'd0);
      chk($sformatf("v%0d_done_ss_mosi", i), {55'd0, dsm}, {55'd0, 8'hFF, 1'b1});
      @(posedge clock); #1;
      chk($sformatf("v%0d_idle_after", i), {61'd0, w_ready, w_rv, w_mosi}, 64'b101);
    end

    // Held req_valid: second command only taken after DONE, data sampled at accept.
    tb_sel = 1'b0; tb_len = 6'd8; tb_data = 64'hA5; tb_ss = 8'h01;
    tb_valid = 1'b1;
    @(posedge clock); #1;
    tb_data = 64'h3C;
    wait_resp(got, lat, rises, highcyc, sscyc, readyhi, dsm, found);
    chk("held_first_data",  got, 64'hA5);
    chk("held_ready_busy",  64'(readyhi), 64'd0);
    @(posedge clock); #1;
    chk("held_ready_idle",  {62'd0, w_ready, w_rv}, 64'b10);
    @(posedge clock); #1;
    chk("held_second_accept", {63'd0, w_ready}, 64'd0);
    tb_valid = 1'b0;
    wait_resp(got, lat, rises, highcyc, sscyc, readyhi, dsm, found);
    chk("held_second_data", got, 64'h3C);
    chk("held_second_lat",  64'(lat), 64'd19);
    @(posedge clock); #1;
    chk("held_one_pulse",   {63'd0, w_rv}, 64'd0);

    // Reset after the third sck rise.
    tb_data = 64'hC3; tb_valid = 1'b1;
    @(posedge clock); #1;
    tb_valid = 1'b0;
    rises = 0;
    begin
      logic prev = 1'b0;
      for (int k = 0; k < 50 && rises < 3; k++) begin
        @(posedge clock); #1;
        if (sck1 && !prev) rises++;
        prev = sck1;
      end
    end
    chk("mid_rst_rises", 64'(rises), 64'd3);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mid_rst_pins",  {53'd0, ss1, sck1, mosi1, if1.req_ready}, {53'd0, 8'hFF, 3'b011});
    chk("mid_rst_rv",    {63'd0, if1.resp_valid}, 64'd0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (if1.resp_valid) cnt++;
    end
    chk("mid_rst_no_resp", 64'(cnt), 64'd0);

    // Slave launching data on sck rise.
`ifdef SPI_SAMPLE_FALL_EN
    exp6 = 64'h3C;
`else
    exp6 = 64'h1E;
`endif
    tb_loop = 1'b0;
    sl_load = 1'b1;
    #1;
    sl_load = 1'b0;
    @(posedge clock); #1;
    tb_data = 64'h0; tb_len = 6'd8; tb_ss = 8'h01; tb_valid = 1'b1;
    @(posedge clock); #1;
    tb_valid = 1'b0;
    wait_resp(got, lat, rises, highcyc, sscyc, readyhi, dsm, found);
    chk("slave_found", {63'd0, found}, 64'd1);
    chk("slave_data",  got, exp6);
    chk("slave_lat",   64'(lat), 64'd19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
